// File: rtl/rgb_buf_pkg.sv
// Shared definitions for the camera-to-HDMI ping-pong line buffer:
// default geometry, read-side state encoding and bank base addressing.
package rgb_buf_pkg;

    localparam int LINE_W_DEF = 640;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_LINE = 1'b1
    } rd_state_e;

    // Bank 0 starts at address 0, bank 1 directly follows it.
    function automatic logic [31:0] bank_base(input logic bank, input int unsigned line_w);
        if (bank) begin
            return 32'(line_w);
        end else begin
            return 32'd0;
        end
    endfunction

endpackage

// File: rtl/rgb_line_pingpong_ctrl_line_ptr.sv
// Per-line pixel pointer: counts accepted pixels, wraps at the end of a line
// and flips the bank it points into.
module line_ptr
    import rgb_buf_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int CNT_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1
) (
    input  logic             i_clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             bank,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_r;
    logic             bank_r;
    logic             wrap_s;

    assign wrap_s = en && (cnt_r == CNT_W'(LINE_W - 1));
    assign cnt    = cnt_r;
    assign bank   = bank_r;
    assign wrap   = wrap_s;

    // Pointer and bank register: clear dominates, wrap moves to the other bank.
    always_ff @(posedge i_clk) begin
        if (clr) begin
            cnt_r  <= {CNT_W{1'b0}};
            bank_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r  <= {CNT_W{1'b0}};
            bank_r <= ~bank_r;
        end else if (en) begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r  <= cnt_r;
        end
    end

endmodule

// File: rtl/rgb_line_pingpong_ctrl.sv
// Ping-pong line buffer controller: camera fills one RAM bank while HDMI drains
// the other; owns addressing, bank ownership and overflow/underflow flags.
module rgb_line_pingpong_ctrl
    import rgb_buf_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              CAM_VSYNC,
    input  logic              CAM_En,
    input  logic [DATA_W-1:0] CAM_DTA,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DTA,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic              HDMI_Req,
    output logic              HDMI_Vld,
    output logic              LINE_Rdy,
    output logic              OVF,
    output logic              UDF
);

    localparam int CNT_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    logic              flush_s;
    logic              wr_acc_s, wr_drop_s, wr_wrap_s, wr_bank_s;
    logic              rd_acc_s, rd_refuse_s, rd_wrap_s, rd_bank_s;
    logic [CNT_W-1:0]  wr_cnt_s, rd_cnt_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [1:0]        full_r, full_nxt_s;
    rd_state_e         state_r, state_nxt_s;
    logic              wr_en_r, hdmi_vld_r, ovf_r, udf_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_dta_r;

    // Frame start behaves exactly like reset and wins over any same-cycle traffic.
    assign flush_s     = i_rst | CAM_VSYNC;
    assign wr_acc_s    = CAM_En & ~full_r[wr_bank_s];
    assign wr_drop_s   = CAM_En &  full_r[wr_bank_s];
    assign rd_acc_s    = HDMI_Req & (state_r == R_LINE);
    assign rd_refuse_s = HDMI_Req & (state_r == R_IDLE);

    assign wr_addr_s = ADDR_W'(bank_base(wr_bank_s, LINE_W) + 32'(wr_cnt_s));
    assign RD_ADDR   = ADDR_W'(bank_base(rd_bank_s, LINE_W) + 32'(rd_cnt_s));

    line_ptr #(.LINE_W(LINE_W), .CNT_W(CNT_W)) u_wr_ptr (
        .i_clk (i_clk),
        .clr   (flush_s),
        .en    (wr_acc_s),
        .cnt   (wr_cnt_s),
        .bank  (wr_bank_s),
        .wrap  (wr_wrap_s)
    );

    line_ptr #(.LINE_W(LINE_W), .CNT_W(CNT_W)) u_rd_ptr (
        .i_clk (i_clk),
        .clr   (flush_s),
        .en    (rd_acc_s),
        .cnt   (rd_cnt_s),
        .bank  (rd_bank_s),
        .wrap  (rd_wrap_s)
    );

    // Bank ownership: completion and release always hit different banks.
    always_comb begin
        full_nxt_s = full_r;
        if (wr_wrap_s) begin
            full_nxt_s[wr_bank_s] = 1'b1;
        end else begin
            full_nxt_s[wr_bank_s] = full_r[wr_bank_s];
        end
        if (rd_wrap_s) begin
            full_nxt_s[rd_bank_s] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_s] = full_nxt_s[rd_bank_s];
        end
    end

    // Read sequencing: one idle cycle per bank swap.
    always_comb begin
        state_nxt_s = R_IDLE;
        case (state_r)
            R_IDLE: begin
                if (full_r[rd_bank_s]) begin
                    state_nxt_s = R_LINE;
                end else begin
                    state_nxt_s = R_IDLE;
                end
            end
            R_LINE: begin
                if (rd_wrap_s) begin
                    state_nxt_s = R_IDLE;
                end else begin
                    state_nxt_s = R_LINE;
                end
            end
            default: state_nxt_s = R_IDLE;
        endcase
    end

    // Control state, sticky flags and registered RAM/HDMI outputs.
    always_ff @(posedge i_clk) begin
        if (flush_s) begin
            full_r     <= 2'b00;
            state_r    <= R_IDLE;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            wr_dta_r   <= {DATA_W{1'b0}};
            hdmi_vld_r <= 1'b0;
            ovf_r      <= 1'b0;
            udf_r      <= 1'b0;
        end else begin
            full_r     <= full_nxt_s;
            state_r    <= state_nxt_s;
            wr_en_r    <= wr_acc_s;
            hdmi_vld_r <= rd_acc_s;
            ovf_r      <= ovf_r | wr_drop_s;
            udf_r      <= udf_r | rd_refuse_s;
            if (wr_acc_s) begin
                wr_addr_r <= wr_addr_s;
                wr_dta_r  <= CAM_DTA;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_dta_r  <= wr_dta_r;
            end
        end
    end

    assign WR_EN    = wr_en_r;
    assign WR_ADDR  = wr_addr_r;
    assign WR_DTA   = wr_dta_r;
    assign HDMI_Vld = hdmi_vld_r;
    assign LINE_Rdy = (state_r == R_LINE);
    assign OVF      = ovf_r;
    assign UDF      = udf_r;

endmodule
